// File: rtl/ff_bank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ff_bank_arbiter: round-robin shared bank of JK-style bits, two requesters. |
// | Optional FF_BANK_LOCK_EN adds a per-requester lock. Revision 1.0           |
// +----------------------------------------------------------------------------+
module ff_bank_arbiter #(
  parameter int IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic [1:0]              req0_op,
  input  logic [IDX_W-1:0]        req0_idx,
  input  logic                    req0_lock,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [1:0]              req1_op,
  input  logic [IDX_W-1:0]        req1_idx,
  input  logic                    req1_lock,
  output logic                    req1_ready,
  output logic [(1<<IDX_W)-1:0]   q,
  output logic [1:0]              grant
);

  localparam int WIDTH = 1 << IDX_W;

  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic             arb0, arb1;
  logic             xfer0, xfer1;
  logic [1:0]       sel_op;
  logic [IDX_W-1:0] sel_idx;

`ifdef FF_BANK_LOCK_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } lock_state_t;

  lock_state_t lock_q, lock_d;
`else
  logic lock_unused;
  assign lock_unused = req0_lock ^ req1_lock;
`endif

  // last_q holds the index of the previous winner; the other side wins a tie.
  always_comb begin
    arb0 = 1'b0;
    arb1 = 1'b0;
    if (req0_valid && req1_valid) begin
      arb0 = last_q;
      arb1 = ~last_q;
    end else begin
      arb0 = req0_valid;
      arb1 = req1_valid;
    end
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst) begin
`ifdef FF_BANK_LOCK_EN
      case (lock_q)
        ST_LOCK0: req0_ready = req0_valid;
        ST_LOCK1: req1_ready = req1_valid;
        default: begin
          req0_ready = arb0;
          req1_ready = arb1;
        end
      endcase
`else
      req0_ready = arb0;
      req1_ready = arb1;
`endif
    end
  end

  assign xfer0   = req0_valid & req0_ready;
  assign xfer1   = req1_valid & req1_ready;
  assign sel_op  = xfer1 ? req1_op  : req0_op;
  assign sel_idx = xfer1 ? req1_idx : req0_idx;

  always_comb begin
    q_d     = q_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (xfer0 || xfer1) begin
      grant_d = xfer1 ? 2'b10 : 2'b01;
      last_d  = xfer1;
      case (sel_op)
        2'b01:   q_d[sel_idx] = 1'b0;
        2'b10:   q_d[sel_idx] = 1'b1;
        2'b11:   q_d[sel_idx] = ~q_q[sel_idx];
        default: q_d = q_q;
      endcase
    end
  end

`ifdef FF_BANK_LOCK_EN
  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      ST_IDLE: begin
        if (xfer0 && req0_lock)      lock_d = ST_LOCK0;
        else if (xfer1 && req1_lock) lock_d = ST_LOCK1;
      end
      ST_LOCK0: if (xfer0 && !req0_lock) lock_d = ST_IDLE;
      ST_LOCK1: if (xfer1 && !req1_lock) lock_d = ST_IDLE;
      default:  lock_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lock_q <= ST_IDLE;
    else      lock_q <= lock_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q     <= '0;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      q_q     <= q_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign q     = q_q;
  assign grant = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_ff_bank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ff_bank_arbiter: directed and random checks against a behavioural model.|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ff_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_lock, req0_ready;
  logic [1:0] req0_op;
  logic [2:0] req0_idx;
  logic       req1_valid, req1_lock, req1_ready;
  logic [1:0] req1_op;
  logic [2:0] req1_idx;
  logic [7:0] q;
  logic [1:0] grant;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] m_q;
  logic [1:0] m_grant;
  int         m_last;
  int         m_owner;

  ff_bank_arbiter #(.IDX_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_idx(req0_idx),
    .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_idx(req1_idx),
    .req1_lock(req1_lock), .req1_ready(req1_ready),
    .q(q), .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic int model_winner();
    if (!rst) return -1;
    if (m_owner == 0) return req0_valid ? 0 : -1;
    if (m_owner == 1) return req1_valid ? 1 : -1;
    if (req0_valid && req1_valid) return 1 - m_last;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_q = 8'h00; m_grant = 2'b00; m_last = 1; m_owner = -1;
  endtask

  // advance one clock, updating the model with the command transferring now
  task automatic tick();
    int w;
    int op;
    int idx;
    logic lk;
    w = model_winner();
    if (w >= 0) begin
      op  = (w == 1) ? int'(req1_op)  : int'(req0_op);
      idx = (w == 1) ? int'(req1_idx) : int'(req0_idx);
      lk  = (w == 1) ? req1_lock : req0_lock;
      if (op == 1) m_q[idx] = 1'b0;
      else if (op == 2) m_q[idx] = 1'b1;
      else if (op == 3) m_q[idx] = ~m_q[idx];
      m_grant = (w == 1) ? 2'b10 : 2'b01;
      m_last  = w;
`ifdef FF_BANK_LOCK_EN
      if (m_owner < 0 && lk) m_owner = w;
      else if (m_owner == w && !lk) m_owner = -1;
`else
      lk = lk;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_op = 0; req0_idx = 0; req0_lock = 0;
    req1_valid = 0; req1_op = 0; req1_idx = 0; req1_lock = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    req0_valid = 1; req1_valid = 1;
    @(posedge clk); @(posedge clk); #1;
    n_vec++;
    if (q !== 8'h00) begin n_err++; $display("FAIL reset_q got=%h exp=00", q); end
    n_vec++;
    if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant got=%b exp=00", grant); end
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b00)
      begin n_err++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    idle_inputs();
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    req0_valid = 1; req0_op = 2'b10; req0_idx = 3;
    #1;
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b10)
      begin n_err++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 0;
    n_vec++;
    if (q !== 8'h08) begin n_err++; $display("FAIL single_q got=%h exp=08", q); end
    n_vec++;
    if (grant !== 2'b01) begin n_err++; $display("FAIL single_grant got=%b exp=01", grant); end
  endtask

  task automatic test_all_ops();
    logic [1:0] ops [5] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b00};
    logic       expb[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    req1_valid = 1; req1_idx = 5;
    for (int i = 0; i < 5; i++) begin
      req1_op = ops[i];
      #1;
      n_vec++;
      if (req1_ready !== 1'b1) begin n_err++; $display("FAIL allops_ready[%0d] got=%b exp=1", i, req1_ready); end
      tick();
      n_vec++;
      if (q !== ({2'b00, expb[i], 5'b0}))
        begin n_err++; $display("FAIL allops_q[%0d] got=%h exp=%h", i, q, {2'b00, expb[i], 5'b0}); end
    end
    req1_valid = 0;
  endtask

  task automatic test_round_robin();
    apply_reset();
    req0_valid = 1; req0_op = 2'b11; req0_idx = 0;
    req1_valid = 1; req1_op = 2'b11; req1_idx = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        begin n_err++; $display("FAIL rr_ready[%0d] got=%b", i, {req0_ready, req1_ready}); end
      tick();
      n_vec++;
      if (grant !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        begin n_err++; $display("FAIL rr_grant[%0d] got=%b", i, grant); end
    end
    n_vec++;
    if (q[1:0] !== 2'b00) begin n_err++; $display("FAIL rr_q got=%b exp=00", q[1:0]); end
    idle_inputs();
  endtask

  task automatic test_same_index();
    apply_reset();
    req0_valid = 1; req0_op = 2'b00;
    tick();
    req0_op = 2'b10; req0_idx = 2;
    req1_valid = 1; req1_op = 2'b01; req1_idx = 2;
    #1;
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b01)
      begin n_err++; $display("FAIL same_first got=%b exp=01", {req0_ready, req1_ready}); end
    tick();
    req1_valid = 0;
    n_vec++;
    if (q[2] !== 1'b0) begin n_err++; $display("FAIL same_q_a got=%b exp=0", q[2]); end
    tick();
    req0_valid = 0;
    n_vec++;
    if (q[2] !== 1'b1 || grant !== 2'b01)
      begin n_err++; $display("FAIL same_q_b got=%b/%b exp=1/01", q[2], grant); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req0_valid = 1; req0_op = 2'b10;
    for (int b = 0; b < 8; b++) begin
      if (b == 0 || b == 2 || b == 5 || b == 7) begin
        req0_idx = 3'(b);
        tick();
      end
    end
    n_vec++;
    if (q !== 8'hA5) begin n_err++; $display("FAIL async_pre got=%h exp=a5", q); end
    req0_op = 2'b11; req0_idx = 0;
    req1_valid = 1; req1_op = 2'b11; req1_idx = 1;
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if (q !== 8'h00 || grant !== 2'b00 || {req0_ready, req1_ready} !== 2'b00)
      begin n_err++; $display("FAIL async_mid got q=%h g=%b r=%b exp 00/00/00", q, grant, {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b10)
      begin n_err++; $display("FAIL async_after got=%b exp=10", {req0_ready, req1_ready}); end
    tick();
    n_vec++;
    if (grant !== 2'b01 || q !== 8'h01)
      begin n_err++; $display("FAIL async_grant got=%b/%h exp=01/01", grant, q); end
    idle_inputs();
  endtask

  task automatic test_lock();
    int k;
    logic [1:0] exp_r;
    apply_reset();
    req1_valid = 1; req1_op = 2'b10; req1_idx = 7;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      req0_valid = 1; req0_op = 2'b10; req0_idx = 3'(k); req0_lock = (k < 3);
      #1;
`ifdef FF_BANK_LOCK_EN
      exp_r = 2'b10;
`else
      exp_r = (c % 2 == 0) ? 2'b10 : 2'b01;
`endif
      n_vec++;
      if ({req0_ready, req1_ready} !== exp_r)
        begin n_err++; $display("FAIL lock_ready[%0d] got=%b exp=%b", c, {req0_ready, req1_ready}, exp_r); end
      if (req0_ready) k++;
      tick();
      n_vec++;
      if (q !== m_q || grant !== m_grant)
        begin n_err++; $display("FAIL lock_state[%0d] got=%h/%b exp=%h/%b", c, q, grant, m_q, m_grant); end
    end
`ifdef FF_BANK_LOCK_EN
    req0_valid = 0;
    #1;
    n_vec++;
    if (req1_ready !== 1'b1) begin n_err++; $display("FAIL lock_release got=%b exp=1", req1_ready); end
    tick();
`endif
    idle_inputs();
  endtask

  task automatic test_random();
    int   w;
    logic hold0, hold1;
    apply_reset();
    hold0 = 0; hold1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold0) begin
        req0_valid = 1'($urandom_range(0, 3) != 0);
        req0_op = 2'($urandom); req0_idx = 3'($urandom);
        req0_lock = 1'($urandom_range(0, 2) == 0);
      end
      if (!hold1) begin
        req1_valid = 1'($urandom_range(0, 3) != 0);
        req1_op = 2'($urandom); req1_idx = 3'($urandom);
        req1_lock = 1'($urandom_range(0, 2) == 0);
      end
      #1;
      w = model_winner();
      n_vec++;
      if (req0_ready !== (w == 0) || req1_ready !== (w == 1))
        begin n_err++; $display("FAIL rand_ready[%0d] got=%b exp_winner=%0d", c, {req0_ready, req1_ready}, w); end
      hold0 = req0_valid && (w != 0);
      hold1 = req1_valid && (w != 1);
      tick();
      n_vec++;
      if (q !== m_q || grant !== m_grant)
        begin n_err++; $display("FAIL rand_state[%0d] got=%h/%b exp=%h/%b", c, q, grant, m_q, m_grant); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_all_ops();
    test_round_robin();
    test_same_index();
    test_async_reset();
    test_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
